// File: rtl/slink_mon_if.sv
// rtl/slink_mon_if.sv - receiver-side and status signals of the serial link monitor
interface slink_mon_if #(
  parameter int CH_NUM = 6
) ();
  logic                     mon_en;
  logic [CH_NUM-1:0]        ch_en;
  logic [CH_NUM-1:0]        rx_eop;
  logic [CH_NUM-1:0]        rx_crc_err;
  logic                     cnt_clr;
  logic [CH_NUM-1:0]        rx_eop_o;
  logic [CH_NUM-1:0]        slink_err;
  logic [16*CH_NUM-1:0]     err_cnt;

  modport master (
    output mon_en, ch_en, rx_eop, rx_crc_err, cnt_clr,
    input  rx_eop_o, slink_err, err_cnt
  );

  modport slave (
    input  mon_en, ch_en, rx_eop, rx_crc_err, cnt_clr,
    output rx_eop_o, slink_err, err_cnt
  );
endinterface

// File: rtl/slink_mon.sv
// rtl/slink_mon.sv - per-channel link health FSM with silence timeout and error counters
module slink_mon #(
  parameter int CH_NUM  = 6,
  parameter int TMO_BIT = 20,
  parameter int TMO_CYC = 1000000,
  parameter int ERR_THR = 3,
  parameter int OK_THR  = 4
) (
  input logic       clk_sys,
  input logic       rst_sys_n,
  slink_mon_if.slave lnk
);

  typedef enum logic [1:0] {IDLE, WAIT, UP} state_t;

  localparam logic [TMO_BIT-1:0] TMO_LAST = TMO_BIT'(TMO_CYC - 1);
  localparam logic [3:0]         OK_N     = 4'(OK_THR);
  localparam logic [3:0]         ERR_N    = 4'(ERR_THR);

  state_t               state_q [CH_NUM];
  state_t               state_d [CH_NUM];
  logic [TMO_BIT-1:0]   tmo_q   [CH_NUM];
  logic [TMO_BIT-1:0]   tmo_d   [CH_NUM];
  logic [3:0]           good_q  [CH_NUM];
  logic [3:0]           good_d  [CH_NUM];
  logic [3:0]           bad_q   [CH_NUM];
  logic [3:0]           bad_d   [CH_NUM];
  logic [15:0]          err_q   [CH_NUM];
  logic [15:0]          err_d   [CH_NUM];
  logic [CH_NUM-1:0]    eop_o_q, eop_o_d;
  logic [CH_NUM-1:0]    lvl_q, lvl_d;
  logic [CH_NUM-1:0]    active, good, bad, tmo_evt;

  assign active = {CH_NUM{lnk.mon_en}} & lnk.ch_en;
  assign good   = lnk.rx_eop & ~lnk.rx_crc_err;
  assign bad    = lnk.rx_eop & lnk.rx_crc_err;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      tmo_d[i]   = tmo_q[i];
      good_d[i]  = good_q[i];
      bad_d[i]   = bad_q[i];
      err_d[i]   = err_q[i];
      eop_o_d[i] = 1'b0;
      tmo_evt[i] = 1'b0;

      if (!active[i]) begin
        state_d[i] = IDLE;
        tmo_d[i]   = '0;
        good_d[i]  = '0;
        bad_d[i]   = '0;
      end else if (state_q[i] == IDLE) begin
        state_d[i] = WAIT;
      end else begin
        eop_o_d[i] = good[i];
        // A frame end in the last timer cycle wins over the timeout.
        tmo_evt[i] = !lnk.rx_eop[i] && (tmo_q[i] == TMO_LAST);
        tmo_d[i]   = (lnk.rx_eop[i] || tmo_evt[i]) ? '0 : tmo_q[i] + TMO_BIT'(1);
        if ((bad[i] || tmo_evt[i]) && (err_q[i] != 16'hFFFF))
          err_d[i] = err_q[i] + 16'd1;

        if (state_q[i] == WAIT) begin
          if (good[i]) begin
            if (good_q[i] + 4'd1 == OK_N) begin
              state_d[i] = UP;
              good_d[i]  = '0;
              bad_d[i]   = '0;
            end else begin
              good_d[i] = good_q[i] + 4'd1;
            end
          end else if (bad[i] || tmo_evt[i]) begin
            good_d[i] = '0;
          end
        end else if (state_q[i] == UP) begin
          if (good[i]) begin
            bad_d[i] = '0;
          end else if ((bad[i] && (bad_q[i] + 4'd1 == ERR_N)) || tmo_evt[i]) begin
            state_d[i] = WAIT;
            good_d[i]  = '0;
            bad_d[i]   = '0;
          end else if (bad[i]) begin
            bad_d[i] = bad_q[i] + 4'd1;
          end
        end
      end

      if (lnk.cnt_clr)
        err_d[i] = '0;
      lvl_d[i] = (state_d[i] == WAIT);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= IDLE;
        tmo_q[i]   <= '0;
        good_q[i]  <= '0;
        bad_q[i]   <= '0;
        err_q[i]   <= '0;
      end
      eop_o_q <= '0;
      lvl_q   <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        tmo_q[i]   <= tmo_d[i];
        good_q[i]  <= good_d[i];
        bad_q[i]   <= bad_d[i];
        err_q[i]   <= err_d[i];
      end
      eop_o_q <= eop_o_d;
      lvl_q   <= lvl_d;
    end
  end

  assign lnk.rx_eop_o  = eop_o_q;
  assign lnk.slink_err = lvl_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_cnt
    assign lnk.err_cnt[16*g +: 16] = err_q[g];
  end

endmodule

// File: tb/tb_slink_mon.sv
// tb/tb_slink_mon.sv - directed bench with good-frame strobe scoreboard for slink_mon
module tb_slink_mon;

  localparam int CH = 6;

  logic clk_sys = 1'b0;
  logic rst_sys_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct { int ch; int cyc; } sb_t;
  sb_t sb[$];

  slink_mon_if #(.CH_NUM(CH)) lnk ();

  slink_mon #(
    .CH_NUM(CH), .TMO_BIT(20), .TMO_CYC(100), .ERR_THR(3), .OK_THR(4)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_sys_n(rst_sys_n),
    .lnk      (lnk)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every good-frame strobe must match the oldest queued expectation.
  always @(negedge clk_sys) begin
    if (rst_sys_n) begin
      for (int c = 0; c < CH; c++) begin
        if (lnk.rx_eop_o[c]) begin
          sb_t e;
          e = (sb.size() > 0) ? sb.pop_front() : '{ch: -1, cyc: -1};
          chk("eop_o_ch", 128'(c), 128'(e.ch));
          chk("eop_o_cyc", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic frame(int ch, bit crc_bad);
    lnk.rx_eop[ch]     = 1'b1;
    lnk.rx_crc_err[ch] = crc_bad;
    if (!crc_bad) sb.push_back('{ch: ch, cyc: cyc + 1});
    tick();
    lnk.rx_eop[ch]     = 1'b0;
    lnk.rx_crc_err[ch] = 1'b0;
  endtask

  task automatic clr_pulse();
    lnk.cnt_clr = 1'b1;
    tick();
    lnk.cnt_clr = 1'b0;
  endtask

  bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    lnk.mon_en = 1'b0;
    lnk.ch_en = '0;
    lnk.rx_eop = '0;
    lnk.rx_crc_err = '0;
    lnk.cnt_clr = 1'b0;
    ticks(3);
    chk("rst_slink_err", 128'(lnk.slink_err), 128'(0));
    chk("rst_eop_o", 128'(lnk.rx_eop_o), 128'(0));
    chk("rst_err_cnt", 128'(lnk.err_cnt), 128'(0));
    rst_sys_n = 1'b1;
    tick();
    chk("idle_slink_err", 128'(lnk.slink_err), 128'(0));

    // Activation and repeated silence timeouts on every channel.
    lnk.mon_en = 1'b1;
    lnk.ch_en = 6'h3F;
    tick();
    chk("act_slink_err", 128'(lnk.slink_err), 128'(6'h3F));
    ticks(99);
    chk("tmo_before", 128'(lnk.err_cnt), 128'(0));
    tick();
    chk("tmo_first", 128'(lnk.err_cnt), 128'({6{16'd1}}));
    ticks(100);
    chk("tmo_second", 128'(lnk.err_cnt), 128'({6{16'd2}}));
    clr_pulse();
    chk("clr_all", 128'(lnk.err_cnt), 128'(0));

    // Channel 2 comes up after four good frames.
    for (int k = 0; k < 4; k++) begin
      frame(2, 1'b0);
      if (k == 2) chk("ch2_wait_3good", 128'(lnk.slink_err[2]), 128'(1));
      if (k == 3) chk("ch2_up_4good", 128'(lnk.slink_err[2]), 128'(0));
      ticks(9);
    end

    // Bad/good mix: bad count restarts on the good frame.
    for (int k = 0; k < 6; k++) begin
      frame(2, pat[k]);
      if (k == 4) chk("ch2_still_up", 128'(lnk.slink_err[2]), 128'(0));
      if (k == 5) chk("ch2_down", 128'(lnk.slink_err[2]), 128'(1));
      ticks(4);
    end
    chk("ch2_err_cnt", 128'(lnk.err_cnt[32 +: 16]), 128'(5));

    // Channel 0: eop on the last timer cycle keeps the link, then silence drops it.
    for (int k = 0; k < 4; k++) begin
      frame(0, 1'b0);
      ticks(1);
    end
    chk("ch0_up", 128'(lnk.slink_err[0]), 128'(0));
    ticks(98);
    frame(0, 1'b0);
    chk("ch0_eop_on_tmo", 128'(lnk.slink_err[0]), 128'(0));
    ticks(99);
    chk("ch0_tmo_minus1", 128'(lnk.slink_err[0]), 128'(0));
    tick();
    chk("ch0_tmo_fired", 128'(lnk.slink_err[0]), 128'(1));

    // Channel 1: disable mid-WAIT restarts good_cnt, keeps err_cnt.
    clr_pulse();
    frame(1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      frame(1, 1'b0);
      ticks(1);
    end
    lnk.ch_en[1] = 1'b0;
    tick();
    chk("ch1_idle", 128'(lnk.slink_err[1]), 128'(0));
    lnk.ch_en[1] = 1'b1;
    tick();
    chk("ch1_rewait", 128'(lnk.slink_err[1]), 128'(1));
    ticks(1);
    frame(1, 1'b0);
    chk("ch1_still_wait", 128'(lnk.slink_err[1]), 128'(1));
    chk("ch1_err_kept", 128'(lnk.err_cnt[16 +: 16]), 128'(1));
    for (int k = 0; k < 3; k++) begin
      ticks(1);
      frame(1, 1'b0);
    end
    chk("ch1_up_after_4", 128'(lnk.slink_err[1]), 128'(0));

    // Channel 4: back-to-back good frames every cycle.
    lnk.rx_eop[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{ch: 4, cyc: cyc + 1});
      tick();
    end
    lnk.rx_eop[4] = 1'b0;
    chk("ch4_b2b_up", 128'(lnk.slink_err[4]), 128'(0));

    // Channel 3: counter saturation and clear priority.
    clr_pulse();
    lnk.rx_eop[3] = 1'b1;
    lnk.rx_crc_err[3] = 1'b1;
    ticks(65535);
    chk("ch3_reach_ffff", 128'(lnk.err_cnt[48 +: 16]), 128'(16'hFFFF));
    tick();
    chk("ch3_sat", 128'(lnk.err_cnt[48 +: 16]), 128'(16'hFFFF));
    lnk.cnt_clr = 1'b1;
    tick();
    lnk.cnt_clr = 1'b0;
    lnk.rx_eop[3] = 1'b0;
    lnk.rx_crc_err[3] = 1'b0;
    chk("ch3_clr_prio", 128'(lnk.err_cnt[48 +: 16]), 128'(0));
    chk("ch3_wait", 128'(lnk.slink_err[3]), 128'(1));

    lnk.mon_en = 1'b0;
    tick();
    chk("mon_off_slink_err", 128'(lnk.slink_err), 128'(0));
    ticks(2);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
